// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga memory subsystem: arbiter FSM states,
// requester identities and the 32-bit bus word type.
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mem_arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } mem_port_e;

    localparam bus32_t BUS_ZERO = 32'h0000_0000;

    // On a tie the port that did not win last time is chosen.
    function automatic mem_port_e pick_port(
        input logic      i_valid,
        input logic      d_valid,
        input mem_port_e lastGrant
    );
        mem_port_e port;
        if (i_valid && d_valid) begin
            port = (lastGrant == PORT_I) ? PORT_D : PORT_I;
        end else if (d_valid) begin
            port = PORT_D;
        end else begin
            port = PORT_I;
        end
        return port;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache line requests onto a single data memory port,
// keeping at most one transaction in flight and returning exactly one response.
module mem_arbiter
    import tartaruga_pkg::*;
#(
    parameter int LINE_W = 128
) (
    input  logic              clk_i,
    input  logic              rstn_i,

    input  logic              i_req_valid_i,
    output logic              i_req_ready_o,
    input  bus32_t            i_addr_i,
    output logic              i_rsp_valid_o,
    input  logic              i_rsp_ready_i,
    output bus32_t            i_rsp_addr_o,
    output logic [LINE_W-1:0] i_data_line_o,

    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  bus32_t            d_addr_i,
    input  logic              d_we_i,
    input  bus32_t            d_data_wr_i,
    output logic              d_rsp_valid_o,
    input  logic              d_rsp_ready_i,
    output bus32_t            d_rsp_addr_o,
    output logic [LINE_W-1:0] d_data_line_o,

    output logic              m_req_valid_o,
    input  logic              m_req_ready_i,
    output bus32_t            m_addr_o,
    output logic              m_we_o,
    output bus32_t            m_data_wr_o,
    input  logic              m_rsp_valid_i,
    output logic              m_rsp_ready_o,
    input  bus32_t            m_rsp_addr_i,
    input  logic [LINE_W-1:0] m_data_line_i
);

    mem_arb_state_t    r_state;
    mem_arb_state_t    w_nextState;
    mem_port_e         r_grant;
    mem_port_e         r_lastGrant;
    bus32_t            r_addr;
    logic              r_we;
    bus32_t            r_wdata;
    bus32_t            r_rspAddr;
    logic [LINE_W-1:0] r_rspLine;

    mem_port_e         w_grant;
    logic              w_accept;
    bus32_t            w_capAddr;
    logic              w_capWe;
    bus32_t            w_capData;
    logic              w_reqHs;
    logic              w_rspCapture;
    logic              w_rspHs;

    assign w_grant = pick_port(i_req_valid_i, d_req_valid_i, r_lastGrant);

    // Readiness is masked during reset so no request is acknowledged and then lost.
    assign w_accept = (r_state == IDLE) && rstn_i && (i_req_valid_i || d_req_valid_i);

    assign i_req_ready_o = w_accept && (w_grant == PORT_I);
    assign d_req_ready_o = w_accept && (w_grant == PORT_D);

    always_comb begin
        w_capAddr = i_addr_i;
        w_capWe   = 1'b0;
        w_capData = BUS_ZERO;
        if (w_grant == PORT_D) begin
            w_capAddr = d_addr_i;
            w_capWe   = d_we_i;
            w_capData = d_data_wr_i;
        end
    end

    assign w_reqHs      = (r_state == ISSUE) && m_req_ready_i;
    assign w_rspCapture = (r_state == WAIT) && m_rsp_valid_i;
    assign w_rspHs      = (r_state == RESP) &&
                          ((r_grant == PORT_I) ? i_rsp_ready_i : d_rsp_ready_i);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state     <= IDLE;
            r_grant     <= PORT_I;
            r_lastGrant <= PORT_I;
            r_addr      <= BUS_ZERO;
            r_we        <= 1'b0;
            r_wdata     <= BUS_ZERO;
            r_rspAddr   <= BUS_ZERO;
            r_rspLine   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_grant <= w_grant;
                r_addr  <= w_capAddr;
                r_we    <= w_capWe;
                r_wdata <= w_capData;
            end
            if (w_rspCapture) begin
                r_rspAddr <= m_rsp_addr_i;
                r_rspLine <= m_data_line_i;
            end
            if (w_rspHs) begin
                r_lastGrant <= r_grant;
            end
        end
    end

    always_comb begin
        w_nextState   = r_state;
        m_req_valid_o = 1'b0;
        m_rsp_ready_o = 1'b0;
        i_rsp_valid_o = 1'b0;
        d_rsp_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                m_req_valid_o = 1'b1;
                if (w_reqHs) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                m_rsp_ready_o = 1'b1;
                if (w_rspCapture) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                i_rsp_valid_o = (r_grant == PORT_I);
                d_rsp_valid_o = (r_grant == PORT_D);
                if (w_rspHs) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign m_addr_o      = r_addr;
    assign m_we_o        = r_we;
    assign m_data_wr_o   = r_wdata;

    assign i_rsp_addr_o  = r_rspAddr;
    assign i_data_line_o = r_rspLine;
    assign d_rsp_addr_o  = r_rspAddr;
    assign d_data_line_o = r_rspLine;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter
Interface
REQ-001 LINE_W, default 128, memory line width in bits.
REQ-002 clk_i  in  1  clock, all state on rising edge.
REQ-003 rstn_i  in  1  synchronous active-low reset.
REQ-004 i_req_valid_i  in  1  icache miss request valid (read only).
REQ-005 i_req_ready_o  out  1  icache request accepted this cycle.
REQ-006 i_addr_i  in  32  icache request address.
REQ-007 i_rsp_valid_o  out  1  icache response valid.
REQ-008 i_rsp_ready_i  in  1  icache response accepted.
REQ-009 i_rsp_addr_o  out  32  address of returned icache line.
REQ-010 i_data_line_o  out  LINE_W  returned icache line.
REQ-011 d_req_valid_i  in  1  dcache request valid.
REQ-012 d_req_ready_o  out  1  dcache request accepted this cycle.
REQ-013 d_addr_i  in  32  dcache request address.
REQ-014 d_we_i  in  1  dcache request is a word store.
REQ-015 d_data_wr_i  in  32  dcache store data.
REQ-016 d_rsp_valid_o  out  1  dcache response valid.
REQ-017 d_rsp_ready_i  in  1  dcache response accepted.
REQ-018 d_rsp_addr_o  out  32  address of returned dcache line.
REQ-019 d_data_line_o  out  LINE_W  returned dcache line.
REQ-020 m_req_valid_o  out  1  request to data memory valid.
REQ-021 m_req_ready_i  in  1  memory accepts request.
REQ-022 m_addr_o  out  32  memory request address.
REQ-023 m_we_o  out  1  memory request is a store.
REQ-024 m_data_wr_o  out  32  memory store data.
REQ-025 m_rsp_valid_i  in  1  memory response valid.
REQ-026 m_rsp_ready_o  out  1  arbiter accepts memory response.
REQ-027 m_rsp_addr_i  in  32  address of memory response line.
REQ-028 m_data_line_i  in  LINE_W  memory response line.
Function
REQ-029 The block SHALL run FSM IDLE, ISSUE, WAIT, RESP with at most one transaction outstanding in total.
REQ-030 IDLE: single valid port granted; both valid -> port not in last_grant granted; granted port's req_ready_o high that cycle only; addr/we/data captured; next state ISSUE.
REQ-031 Handshakes: a transfer occurs when valid and ready are both high on a rising edge; req_ready_o SHALL be 0 in every state except IDLE; ungranted request remains pending untouched.
REQ-032 ISSUE: m_req_valid_o=1 with captured fields held stable until m_req_ready_i; on handshake -> WAIT; icache grants drive m_we_o=0, m_data_wr_o=0.
REQ-033 WAIT: m_rsp_ready_o=1; on m_rsp_valid_i capture m_rsp_addr_i and m_data_line_i -> RESP; m_rsp_ready_o=0 and m_rsp_valid_i ignored in all other states.
REQ-034 RESP: only the granted port's rsp_valid_o=1, addr/line held stable until its rsp_ready_i; on handshake last_grant updated to granted port and -> IDLE.
REQ-035 Every accepted request, stores included, SHALL produce exactly one response; store response carries the line returned by memory.
REQ-036 Latency: accept at cycle N -> m_req_valid_o at N+1; with memory ready and responding immediately, rsp_valid_o at N+3; next accept no earlier than cycle after response handshake.
Reset
REQ-037 On rstn_i low at a clock edge: state IDLE, last_grant=I (first tie goes to D), all valid/ready outputs 0, captured address/data/line registers 0; an in-flight transaction is abandoned with no response; memory and caches are reset in the same cycle.
Structure
REQ-038 tartaruga_pkg SHALL hold mem_arb_state_t (IDLE, ISSUE, WAIT, RESP) and mem_port_e (PORT_I, PORT_D); bus32_t is used for all 32-bit fields; single module, no sub-module.
Verification
REQ-039 i req 0x100, memory ready, rsp line all 0xA -> i_rsp_valid_o at N+3, i_rsp_addr_o=0x100, line all 0xA; d_rsp_valid_o stays 0.
REQ-040 i 0x200 and d 0x300 both valid after reset -> m_addr_o=0x300 first, then 0x200; i held pending with i_req_ready_o=0 until second IDLE.
REQ-041 d store 0x40000004 data 0xDEADBEEF -> m_we_o=1, m_data_wr_o=0xDEADBEEF, exactly one d response.
REQ-042 m_req_ready_i low 5 cycles -> m_req_valid_o, m_addr_o stable all 5 cycles; both req_ready_o 0.
REQ-043 d_rsp_ready_i low 3 cycles in RESP -> d_rsp_valid_o and line stable; rstn_i low then -> all valid/ready outputs 0 next cycle, FSM IDLE.
